einstein_mem_arbiter: RTL
=========================

# einstein_mem_arbiter

Sequential SDRAM access arbiter placed directly upstream of the byte-wide `sdram` controller in the Einstein core. It merges two request sources into one stream of single-byte requests and holds each request until the controller acknowledges it. The first source is ROM download writes from `data_io`, buffered in a 4-entry FIFO. The second is CPU memory cycles from `tatung` (RAM read/write, main ROM, diagnostic ROM). It also stalls the CPU while an access is in flight and returns latched read data.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: download write buffer entries (power of two, ≥2).

Ports:
- `clk_sys` in 1: system clock (32 MHz); sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_wr` in 1: one-cycle download write strobe.
- `ioctl_addr` in 15: download byte address.
- `ioctl_dout` in 8: download byte.
- `cpu_addr` in 16: CPU address.
- `cpu_din` in 8: CPU write data.
- `cpu_ram_rd`, `cpu_ram_wr`, `cpu_roma_rd`, `cpu_romb_rd` in 1 each: CPU request levels.
- `cpu_dout` out 8: latched read data.
- `cpu_wait` out 1: CPU stall.
- `sdram_addr` out 23: byte address to the controller.
- `sdram_din` out 8: write data.
- `sdram_rd`, `sdram_we` out 1 each: request levels.
- `sdram_dout` in 8: read data, valid in the `sdram_ready` cycle.
- `sdram_ready` in 1: one-cycle access-complete pulse.
- `dl_overflow` out 1: sticky; a download write was dropped.

## Operation
Address map (23-bit):
- Download: `ioctl_addr`.
- Main ROM: `cpu_addr[13:0]`.
- Diagnostic ROM: `0x04000 + cpu_addr[13:0]`.
- RAM: `0x10000 + cpu_addr[15:0]`.

Download FIFO:
- Each `ioctl_wr` pushes {addr, data}.
- A push while full is dropped and sets `dl_overflow`.
- A push and a pop in the same cycle while full is accepted.
- `dl_overflow` clears on `reset_n` low or on a rising edge of `ioctl_download`.

CPU request capture:
- `any = |{ram_rd, ram_wr, roma_rd, romb_rd}`. A rising edge of `any` (`any` & ~`any_q`) captures one request.
- Capture is ignored while `ioctl_download` = 1.
- Priority when several levels are high at the edge: `ram_wr` > `ram_rd` > `roma_rd` > `romb_rd`.
- Captured fields: type, mapped address, `cpu_din`.
- One pending slot: an edge arriving while busy is stored and served after the current access.
- Levels held high never generate a second request.

FSM states: IDLE, DL_WR, CPU_RD, CPU_WR.
- IDLE → DL_WR when the FIFO is non-empty. This path has priority over a pending CPU request.
- IDLE → CPU_RD or CPU_WR when a CPU request is pending.
- Any busy state → IDLE on `sdram_ready`.
- DL_WR pops its FIFO entry on `sdram_ready`.
- CPU_RD loads `cpu_dout` ← `sdram_dout` on `sdram_ready`.

Output rules:
- `sdram_rd` = 1 only in CPU_RD. `sdram_we` = 1 only in DL_WR or CPU_WR. Never both.
- `sdram_addr` and `sdram_din` are registered and stable for the whole request.
- `sdram_din` = 0 during reads.
- `cpu_wait` = 1 from the cycle after a captured edge until the cycle after that request's `sdram_ready`.
- `cpu_dout` holds its value until the next completed CPU read. CPU writes leave it unchanged.
- `sdram_ready` while in IDLE is ignored.

## Timing
- Reset values: `sdram_rd`/`sdram_we`/`cpu_wait`/`dl_overflow` = 0; `sdram_addr` = 0; `sdram_din` = 0; `cpu_dout` = 8'hFF; FIFO empty; FSM in IDLE; pending cleared.
- CPU edge sampled at edge N: `cpu_wait` = 1 and `sdram_rd`/`sdram_we` = 1 from N+1 (when idle).
- `sdram_ready` high at edge M: request deasserted from M+1; `cpu_dout` valid and `cpu_wait` = 0 from M+1.
- Back-to-back: IDLE spends exactly one cycle between accesses.
- `ioctl_wr` at edge N with FIFO empty and FSM idle: `sdram_we` from N+2.
- Reset asserted mid-access: all outputs drop asynchronously; the access is abandoned and the FIFO contents lost.

## Test plan
- Download burst: 8 consecutive `ioctl_wr` (addr 0–7, data 0xA0–0xA7), controller ready 3 cycles after each request → 8 writes in order at 0x00000–0x00007, `dl_overflow` = 0.
- Overflow: 6 back-to-back `ioctl_wr` with `sdram_ready` held 0 → 4 retained, `dl_overflow` = 1. Release ready → exactly 4 writes. New `ioctl_download` rise → `dl_overflow` = 0.
- CPU reads: `cpu_roma_rd` addr 0x1234 → `sdram_addr` 0x01234; `cpu_romb_rd` 0x0010 → 0x04010; `cpu_ram_rd` 0xFFFF → 0x1FFFF. With `sdram_dout` = 0x5A → `cpu_dout` = 0x5A; `cpu_wait` 1 for ready latency + 1 cycles.
- CPU write with overlap: `ram_wr` and `ram_rd` high in the same cycle, addr 0x8000, din 0x3C → single write of 0x3C at 0x18000, no read issued. Level held 10 cycles → still one access.
- Arbitration: CPU edge and `ioctl_wr` in the same cycle with `ioctl_download` = 0 → download write first, then CPU access after one idle cycle.
- Reset mid-read: drop `reset_n` while `sdram_rd` = 1 → outputs at reset values immediately; `cpu_dout` = 0xFF.

Source files
------------

// File: rtl/einstein_mem_arbiter.sv
// rtl/einstein_mem_arbiter.sv - merges download writes and CPU cycles into single-byte SDRAM requests
module einstein_mem_arbiter #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [14:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   input  logic        cpu_ram_rd,
   input  logic        cpu_ram_wr,
   input  logic        cpu_roma_rd,
   input  logic        cpu_romb_rd,
   output logic [7:0]  cpu_dout,
   output logic        cpu_wait,
   output logic [22:0] sdram_addr,
   output logic [7:0]  sdram_din,
   output logic        sdram_rd,
   output logic        sdram_we,
   input  logic [7:0]  sdram_dout,
   input  logic        sdram_ready,
   output logic        dl_overflow
);
   localparam int          AW    = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DL_WR, CPU_RD, CPU_WR} state_t;
   state_t state;

   logic [14:0]   fifo_addr [FIFO_DEPTH];
   logic [7:0]    fifo_data [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          fifo_empty, fifo_full, push, pop, drop;

   logic          any, any_q, dl_q, capture, direct, take_pend;
   logic          cap_wr;
   logic [22:0]   cap_addr;
   logic          pend_valid, pend_wr;
   logic [22:0]   pend_addr;
   logic [7:0]    pend_din;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH);
   assign pop        = (state == DL_WR) && sdram_ready;
   assign push       = ioctl_wr && (!fifo_full || pop);
   assign drop       = ioctl_wr && fifo_full && !pop;

   assign any       = cpu_ram_rd | cpu_ram_wr | cpu_roma_rd | cpu_romb_rd;
   assign capture   = any && !any_q && !ioctl_download;
   // A CPU edge bypasses the pending slot only if no download write is queued or arriving now
   assign direct    = capture && (state == IDLE) && fifo_empty && !ioctl_wr && !pend_valid;
   assign take_pend = (state == IDLE) && fifo_empty && pend_valid;

   always_comb begin
      cap_wr   = cpu_ram_wr;
      cap_addr = {9'd0, cpu_addr[13:0]};
      if (cpu_ram_wr || cpu_ram_rd)
         cap_addr = {7'd1, cpu_addr};
      else if (!cpu_roma_rd)
         cap_addr = {8'd0, 1'b1, cpu_addr[13:0]};
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_addr[wr_ptr] <= ioctl_addr;
         fifo_data[wr_ptr] <= ioctl_dout;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         any_q       <= 1'b0;
         dl_q        <= 1'b0;
         dl_overflow <= 1'b0;
         pend_valid  <= 1'b0;
         pend_wr     <= 1'b0;
         pend_addr   <= '0;
         pend_din    <= '0;
         cpu_dout    <= 8'hFF;
         cpu_wait    <= 1'b0;
         sdram_addr  <= '0;
         sdram_din   <= '0;
         sdram_rd    <= 1'b0;
         sdram_we    <= 1'b0;
      end else begin
         any_q <= any;
         dl_q  <= ioctl_download;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);

         if (ioctl_download && !dl_q)
            dl_overflow <= drop;
         else if (drop)
            dl_overflow <= 1'b1;

         if (capture && !direct) begin
            pend_valid <= 1'b1;
            pend_wr    <= cap_wr;
            pend_addr  <= cap_addr;
            pend_din   <= cpu_din;
         end else if (take_pend) begin
            pend_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state      <= DL_WR;
                  sdram_we   <= 1'b1;
                  sdram_addr <= {8'd0, fifo_addr[rd_ptr]};
                  sdram_din  <= fifo_data[rd_ptr];
               end else if (pend_valid) begin
                  state      <= pend_wr ? CPU_WR : CPU_RD;
                  sdram_rd   <= !pend_wr;
                  sdram_we   <= pend_wr;
                  sdram_addr <= pend_addr;
                  sdram_din  <= pend_wr ? pend_din : 8'h00;
               end else if (direct) begin
                  state      <= cap_wr ? CPU_WR : CPU_RD;
                  sdram_rd   <= !cap_wr;
                  sdram_we   <= cap_wr;
                  sdram_addr <= cap_addr;
                  sdram_din  <= cap_wr ? cpu_din : 8'h00;
               end
            end
            default: begin
               if (sdram_ready) begin
                  state    <= IDLE;
                  sdram_rd <= 1'b0;
                  sdram_we <= 1'b0;
                  if (state == CPU_RD)
                     cpu_dout <= sdram_dout;
                  // A CPU request still queued keeps the CPU stalled
                  if (state != DL_WR && !pend_valid)
                     cpu_wait <= 1'b0;
               end
            end
         endcase

         if (capture)
            cpu_wait <= 1'b1;
      end
   end
endmodule
